// File: rtl/vector_pred_writeback.sv
// Predicated vector write-back: turns registered compare flags into byte enables and
// buffers up to two register-file writes. Define VECTOR_PRED_WRITEBACK_STATS_EN for the suppressed-write counter.
module vector_pred_writeback #(
  parameter int NUM_ELEMS  = 8,
  parameter int ELEM_SIZE  = 16,
  parameter int ADDR_WIDTH = 5,
  localparam int DW = NUM_ELEMS*ELEM_SIZE,
  localparam int NB = DW/8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [2:0]            in_cond,
  input  logic [NB-1:0]         vcr_eq,
  input  logic [NB-1:0]         vcr_gt,
  input  logic [NB-1:0]         vcr_lt,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic [NB-1:0]         wr_be
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
  ,
  output logic [31:0]           supp_count,
  input  logic                  supp_clear
`endif
);

  logic [NB-1:0] m;
  always_comb begin
    m = '0;
    case (in_cond)
      3'd0: m = '1;
      3'd1: m = vcr_eq;
      3'd2: m = vcr_gt;
      3'd3: m = vcr_lt;
      3'd4: m = ~vcr_eq;
      3'd5: m = vcr_gt | vcr_eq;
      3'd6: m = vcr_lt | vcr_eq;
      default: m = '0;
    endcase
  end

  logic [ADDR_WIDTH-1:0] ent_addr [2];
  logic [DW-1:0]         ent_data [2];
  logic [NB-1:0]         ent_be   [2];
  logic                  wptr, rptr;
  logic [1:0]            count;

  logic accept, push, pop;
  assign in_ready = (count != 2'd2);
  assign wr_valid = (count != 2'd0);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (m != '0);
  assign pop      = wr_valid && wr_ready;

  assign wr_addr = ent_addr[rptr];
  assign wr_data = ent_data[rptr];
  assign wr_be   = ent_be[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[wptr] <= in_addr;
        ent_data[wptr] <= in_data;
        ent_be[wptr]   <= m;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
  // Clear wins over a suppressed accept in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || supp_clear)
      supp_count <= '0;
    else if (accept && (m == '0) && (supp_count != 32'hFFFF_FFFF))
      supp_count <= supp_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vector_pred_writeback.sv
// Directed bench for vector_pred_writeback: a queue scoreboard checks every write at the
// register-file port while the initial block walks through the directed scenarios.
module tb_vector_pred_writeback;
  localparam int DW = 128;
  localparam int NB = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic [2:0]    in_cond = '0;
  logic [NB-1:0] vcr_eq = '0, vcr_gt = '0, vcr_lt = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
  logic [31:0]   supp_count;
  logic          supp_clear = 1'b0;
`endif

  vector_pred_writeback #(.NUM_ELEMS(8), .ELEM_SIZE(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_cond(in_cond), .vcr_eq(vcr_eq), .vcr_gt(vcr_gt), .vcr_lt(vcr_lt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be)
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
    , .supp_count(supp_count), .supp_clear(supp_clear)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
  } wr_t;

  wr_t         sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          started = 0;
  int          mcount = 0;
  logic [31:0] msupp = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pred(input logic [2:0] c, input logic [NB-1:0] e, g, l);
    case (c)
      3'd0: return {NB{1'b1}};
      3'd1: return e;
      3'd2: return g;
      3'd3: return l;
      3'd4: return ~e;
      3'd5: return g | e;
      3'd6: return l | e;
      default: return '0;
    endcase
  endfunction

  // Scoreboard: sampled on the falling edge, mid-cycle, where inputs are stable.
  always @(negedge clk) if (started) begin
    logic          acc, pop;
    logic [NB-1:0] m;
    chk("in_ready", {127'b0, in_ready}, {127'b0, mcount != 2});
    chk("wr_valid", {127'b0, wr_valid}, {127'b0, mcount != 0});
    if (mcount != 0) begin
      chk("wr_addr", {123'b0, wr_addr}, {123'b0, sb[0].addr});
      chk("wr_data", wr_data, sb[0].data);
      chk("wr_be", {112'b0, wr_be}, {112'b0, sb[0].be});
    end
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
    chk("supp_count", {96'b0, supp_count}, {96'b0, msupp});
`endif
    if (reset) begin
      sb.delete();
      mcount = 0;
      msupp  = '0;
    end else begin
      acc = in_valid && (mcount != 2);
      m   = pred(in_cond, vcr_eq, vcr_gt, vcr_lt);
      pop = (mcount != 0) && wr_ready;
      if (pop) void'(sb.pop_front());
      if (acc && m != '0) sb.push_back('{in_addr, in_data, m});
      mcount = sb.size();
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
      if (supp_clear) msupp = '0;
      else if (acc && m == '0 && msupp != 32'hFFFF_FFFF) msupp = msupp + 1;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] c,
                       input logic [NB-1:0] e, input logic [NB-1:0] g, input logic [NB-1:0] l);
    in_valid = 1'b1; in_addr = a; in_data = d; in_cond = c;
    vcr_eq = e; vcr_gt = g; vcr_lt = l;
  endtask

  initial begin
    logic [DW-1:0] da, dbv, dc;
    da  = {8{16'hAAAA}};
    dbv = {8{16'hBBBB}};
    dc  = {8{16'hCCCC}};

    tick();
    started = 1;
    tick();
    reset = 1'b0;
    chk("rst_wr_valid", {127'b0, wr_valid}, '0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_wr_addr", {123'b0, wr_addr}, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_be", {112'b0, wr_be}, '0);
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
    chk("rst_supp", {96'b0, supp_count}, '0);
`endif

    // ALWAYS write, drained immediately
    wr_ready = 1'b1;
    drive(5'd3, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 3'd0, '0, '0, '0);
    tick();
    in_valid = 1'b0;
    chk("always_valid", {127'b0, wr_valid}, 128'd1);
    chk("always_addr", {123'b0, wr_addr}, 128'd3);
    chk("always_be", {112'b0, wr_be}, 128'hFFFF);
    tick();
    chk("always_empty", {127'b0, wr_valid}, '0);

    // EQ then NE with the same flags
    drive(5'd4, {8{16'h1234}}, 3'd1, 16'hF00F, 16'h0AA0, 16'h0550);
    tick();
    in_valid = 1'b0;
    chk("eq_be", {112'b0, wr_be}, 128'hF00F);
    tick();
    drive(5'd5, {8{16'h5678}}, 3'd4, 16'hF00F, 16'h0AA0, 16'h0550);
    tick();
    in_valid = 1'b0;
    chk("ne_be", {112'b0, wr_be}, 128'h0FF0);
    tick();

    // NEVER and GT with no greater flags are both suppressed
    drive(5'd6, '1, 3'd7, '1, '1, '1);
    tick();
    drive(5'd7, '1, 3'd2, '1, 16'h0000, '1);
    tick();
    in_valid = 1'b0;
    chk("supp_no_write", {127'b0, wr_valid}, '0);
`ifdef VECTOR_PRED_WRITEBACK_STATS_EN
    chk("supp_two", {96'b0, supp_count}, 128'd2);
    supp_clear = 1'b1;
    drive(5'd7, '1, 3'd7, '0, '0, '0);
    tick();
    supp_clear = 1'b0;
    in_valid = 1'b0;
    chk("supp_clear_prio", {96'b0, supp_count}, '0);
`endif

    // Stall: A and B fill the FIFO, C is held off
    wr_ready = 1'b0;
    drive(5'd10, da, 3'd0, '0, '0, '0);
    tick();
    drive(5'd11, dbv, 3'd5, 16'h00FF, 16'hFF00, 16'h0000);
    tick();
    drive(5'd12, dc, 3'd6, 16'h0F0F, 16'h0000, 16'hF000);
    chk("full_in_ready", {127'b0, in_ready}, '0);
    chk("stall_head_a", {123'b0, wr_addr}, 128'd10);
    tick();
    tick();
    chk("stall_hold_addr", {123'b0, wr_addr}, 128'd10);
    chk("stall_hold_data", wr_data, da);
    // Pop while full: no accept this cycle, C goes in next cycle
    wr_ready = 1'b1;
    tick();
    chk("pop_full_head_b", {123'b0, wr_addr}, 128'd11);
    chk("pop_full_be_b", {112'b0, wr_be}, 128'hFFFF);
    chk("pop_full_ready", {127'b0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("head_c", {123'b0, wr_addr}, 128'd12);
    chk("be_c", {112'b0, wr_be}, 128'hFF0F);
    tick();

    // Reset with two queued entries discards them
    wr_ready = 1'b0;
    drive(5'd20, da, 3'd0, '0, '0, '0);
    tick();
    drive(5'd21, dbv, 3'd0, '0, '0, '0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid", {127'b0, wr_valid}, '0);
    chk("rst_mid_ready", {127'b0, in_ready}, 128'd1);
    wr_ready = 1'b1;
    tick();
    tick();

    // Back-to-back random traffic at full throughput
    for (int i = 0; i < 24; i++) begin
      drive(5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom},
            3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom));
      wr_ready = (i < 12) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (4) tick();
    chk("drained", {127'b0, wr_valid}, '0);

    @(negedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vector_pred_writeback.md
# vector_pred_writeback

- Predicated write-back stage directly downstream of the vector compare unit.
- Accepts vector results bound for the vector register file and turns the registered per-byte compare flags (eq/gt/lt) into byte-write enables, according to a per-instruction condition code.
- Buffers up to two pending writes in a FIFO, so register-file port backpressure does not stall the vector ALU issue.

## Interface
Parameters:
- NUM_ELEMS, 8, number of vector elements
- ELEM_SIZE, 16, element width in bits; multiple of 8
- ADDR_WIDTH, 5, vector register address width
- Derived: NB = NUM_ELEMS*ELEM_SIZE/8, the byte count of one vector

Ports (clock and reset first):
- clk, input, 1, clock
- reset, input, 1, synchronous, active-high
- in_valid, input, 1, write request present
- in_ready, output, 1, stage can accept a request
- in_data, input, NUM_ELEMS*ELEM_SIZE, result vector; element 0 in the MSBs
- in_addr, input, ADDR_WIDTH, destination vector register
- in_cond, input, 3, predicate code
- vcr_eq, input, NB, per-byte equal flags from the compare stage; bit NB-1 = byte 0
- vcr_gt, input, NB, per-byte greater flags from the compare stage; bit NB-1 = byte 0
- vcr_lt, input, NB, per-byte less flags from the compare stage; bit NB-1 = byte 0
- wr_valid, output, 1, register-file write pending
- wr_ready, input, 1, register-file port grants the write
- wr_addr, output, ADDR_WIDTH, write address
- wr_data, output, NUM_ELEMS*ELEM_SIZE, write data
- wr_be, output, NB, byte enables; bit NB-1 = byte 0
- Stats ports (present only with the macro in Configuration):
  - supp_count, output, 32, suppressed-write counter
  - supp_clear, input, 1, synchronous counter clear

## Operation
- Byte mask m is computed combinationally from in_cond and the current vcr_* values:
  - 0 ALWAYS: all ones
  - 1 EQ: eq
  - 2 GT: gt
  - 3 LT: lt
  - 4 NE: ~eq
  - 5 GE: gt|eq
  - 6 LE: lt|eq
  - 7 NEVER: all zeros
- Accept occurs when in_valid && in_ready.
- On accept with m != 0: push {in_addr, in_data, m} into a 2-entry FIFO.
- On accept with m == 0: the request is consumed and dropped, never pushed, and counts as suppressed.
- FIFO implementation: two entry registers, 1-bit read and write pointers, 2-bit occupancy count (0..2).
- Head output:
  - wr_valid = (count != 0)
  - wr_addr, wr_data, wr_be = head entry
- Pop occurs when wr_valid && wr_ready.
- in_ready = (count != 2). It depends only on registered state and never combinationally on wr_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop without push: count decrements.
- Pointers wrap modulo 2.
- Head outputs stay stable while wr_valid && !wr_ready.
- vcr_* are sampled only in the accept cycle. Later changes do not affect queued entries.

## Timing
- Reset values: count=0, pointers=0, wr_valid=0, in_ready=1, wr_addr=0, wr_data=0, wr_be=0, supp_count=0.
- Latency: a request accepted in cycle N shows wr_valid=1 in cycle N+1. If wr_ready=1 in N+1, the write completes in N+1.
- Throughput: one write per cycle when wr_ready is held high.
- Full FIFO (count=2): in_ready=0 even if a pop happens in the same cycle, and no accept occurs that cycle.
- Empty FIFO: wr_ready is ignored and no pop occurs.
- Reset asserted mid-operation: all queued entries are discarded at the next clock edge. There is no partial write.
- The upstream compare result is registered, so the issuing logic presents in_* in the cycle after the compare that produced the vcr values.

## Configuration
- Macro: VECTOR_PRED_WRITEBACK_STATS_EN
- Defined:
  - supp_count and supp_clear ports exist.
  - supp_count increments by 1 for every accept with m == 0 and saturates at 32'hFFFF_FFFF.
  - supp_clear has priority: the counter becomes 0 in that cycle, even if a suppressed accept occurs in the same cycle.
- Undefined:
  - both ports are absent, no counter logic exists, and datapath behaviour is identical.

## Test plan
- Reset, then an ALWAYS write to addr 3 with data 0x0001_…_0008 and wr_ready=1 -> next cycle: wr_valid=1, wr_addr=3, wr_be=16'hFFFF. After the pop the FIFO is empty.
- Condition EQ with vcr_eq=16'hF00F -> wr_be=16'hF00F. Condition NE with the same flags -> wr_be=16'h0FF0.
- NEVER, and separately GT with vcr_gt=0 -> wr_valid stays 0 and supp_count becomes 2 (with the macro defined).
- wr_ready=0, three back-to-back requests A, B, C -> A and B accepted, in_ready=0 during C's cycle. Raise wr_ready -> writes occur in order A, B, C, and head outputs are unchanged while stalled.
- Count=2 with wr_ready=1 and in_valid=1 -> the pop occurs, no accept that cycle, and the accept occurs on the next cycle.
- Reset asserted with 2 queued entries -> next cycle: wr_valid=0, in_ready=1, and no write is issued for the discarded entries.
